// File: rtl/delay_addr_gen.sv
// delay_addr_gen: circular write/read address sequencer for the echo RAM.
// Optional macro DELAY_FILL_MUTE_EN mutes RAM reads until the ring is filled.
module delay_addr_gen #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    input  logic [DATA_WIDTH-1:0]    sample_in,
    output logic                     wr,
    output logic                     rd,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    din,
    output logic                     out_valid,
    output logic                     filling
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDRESS_WIDTH-1:0] dly_q, dly_d;
    logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                     wr_q, wr_d;
    logic                     rd_q, rd_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;
    logic                     out_valid_q, out_valid_d;

    logic [ADDRESS_WIDTH-1:0] d_eff;
    logic [ADDRESS_WIDTH-1:0] fill_inc;
    logic                     changed;

    // Next-state, fill tracking and registered RAM port values.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        dly_d       = dly_q;
        fill_cnt_d  = fill_cnt_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        din_d       = din_q;
        out_valid_d = rd_q;
        // A zero delay would read the address being written.
        d_eff       = (delay != '0) ? delay : ONE;
        fill_inc    = fill_cnt_q + ONE;
        changed     = (d_eff != dly_q);

        if (en) begin
            wr_d      = 1'b1;
            wr_addr_d = wptr_q;
            din_d     = sample_in;
            rd_addr_d = wptr_q - d_eff;
            wptr_d    = wptr_q + ONE;
`ifdef DELAY_FILL_MUTE_EN
            rd_d      = (state_q == RUN) && !changed;
`else
            rd_d      = 1'b1;
`endif
            unique case (state_q)
                IDLE: begin
                    dly_d      = d_eff;
                    fill_cnt_d = ONE;
                    state_d    = (d_eff == ONE) ? RUN : FILL;
                end
                FILL: begin
                    if (changed) begin
                        dly_d      = d_eff;
                        fill_cnt_d = ONE;
                        state_d    = (d_eff == ONE) ? RUN : FILL;
                    end else begin
                        fill_cnt_d = fill_inc;
                        if (fill_inc == dly_q) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (changed) begin
                        dly_d      = d_eff;
                        fill_cnt_d = ONE;
                        state_d    = (d_eff == ONE) ? RUN : FILL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            dly_q       <= '0;
            fill_cnt_q  <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            din_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            dly_q       <= dly_d;
            fill_cnt_q  <= fill_cnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            din_q       <= din_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign wr        = wr_q;
    assign rd        = rd_q;
    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign din       = din_q;
    assign out_valid = out_valid_q;
    assign filling   = (state_q != RUN);

endmodule
